// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller.
//
// Combines stall requests from IF/ID/EX/MEM with exception and
// branch-mispredict events. It produces the stage-register stall vector,
// the flush strobe and its cause, and the fetch redirect.
//
// The only state is a "mispredict already flushed" flag and two saturating
// performance counters. Everything else is combinational in the current cycle.
//
// Handshake note: there is no valid/ready pair here. redirect_valid_o
// qualifies new_pc_o in the same cycle. Fetch loads new_pc_o at the edge
// that ends a cycle in which redirect_valid_o = 1.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   stallreq_{if,id,ex,mem}_i per-stage stall requests
//   excp_valid_i/target_i    exception committed in MEM and its handler PC
//   mispredict_i/target_i    BRU misprediction in EX and the correct PC
//   stall_o[3:0]             bit3 PC/IF-ID, bit0 ID-EX, bit1 EX-MEM, bit2 MEM-WB
//   flush_o, flush_cause_o   flush strobe and cause (EXCEPTION / FAILED_BP)
//   new_pc_o, redirect_valid_o fetch redirect
//   perf_stall_cnt_o         saturating count of cycles with stall_o != 0
//   perf_flush_cnt_o         saturating count of cycles with flush_o = 1
//   mp_done_o                debug view of the mispredict-done state
module pipe_ctrl #(
    parameter int   CNT_W     = 32,
    parameter logic EXCEPTION = 1'b1,
    parameter logic FAILED_BP = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if_i,
    input  logic             stallreq_id_i,
    input  logic             stallreq_ex_i,
    input  logic             stallreq_mem_i,
    input  logic             excp_valid_i,
    input  logic [31:0]      excp_target_i,
    input  logic             mispredict_i,
    input  logic [31:0]      mispredict_target_i,
    output logic [3:0]       stall_o,
    output logic             flush_o,
    output logic             flush_cause_o,
    output logic [31:0]      new_pc_o,
    output logic             redirect_valid_o,
    output logic [CNT_W-1:0] perf_stall_cnt_o,
    output logic [CNT_W-1:0] perf_flush_cnt_o,
    output logic             mp_done_o
);

    localparam logic [0:0] MP_IDLE = 1'b0;
    localparam logic [0:0] MP_DONE = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       mp_state;
    logic [3:0]       base_stall;
    logic             mp_flush;
    logic             mp_set;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Highest-numbered requesting stage decides how much of the pipe freezes.
    always_comb begin
        base_stall = 4'b0000;
        if (stallreq_mem_i)     base_stall = 4'b1111;
        else if (stallreq_ex_i) base_stall = 4'b1011;
        else if (stallreq_id_i) base_stall = 4'b1001;
        else if (stallreq_if_i) base_stall = 4'b1000;
    end

    // A fresh mispredict flushes at once unless MEM is stalled. In that case
    // the branch stays in EX and presents the mispredict again next cycle.
    assign mp_flush = mispredict_i && (mp_state == MP_IDLE) && !stallreq_mem_i;

    // With EX busy, the branch stays in ID-EX after its flush.
    // Remember that, so the re-presented mispredict does not flush a second time.
    assign mp_set = !excp_valid_i && mp_flush && stallreq_ex_i;

    always_comb begin
        stall_o          = base_stall;
        flush_o          = 1'b0;
        flush_cause_o    = FAILED_BP;
        new_pc_o         = 32'h0;
        redirect_valid_o = 1'b0;
        if (!rst) begin
            stall_o = 4'b0000;
        end else if (excp_valid_i) begin
            stall_o          = 4'b0000;
            flush_o          = 1'b1;
            flush_cause_o    = EXCEPTION;
            new_pc_o         = excp_target_i;
            redirect_valid_o = 1'b1;
        end else if (mp_flush) begin
            // Redirect overrides any IF stall: bit3 is always 0 here.
            stall_o          = stallreq_ex_i ? 4'b0011 : 4'b0000;
            flush_o          = 1'b1;
            flush_cause_o    = FAILED_BP;
            new_pc_o         = mispredict_target_i;
            redirect_valid_o = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mp_state  <= MP_IDLE;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (excp_valid_i)     mp_state <= MP_IDLE;
            else if (mp_set)      mp_state <= MP_DONE;
            else if (!stall_o[1]) mp_state <= MP_IDLE;  // EX advanced

            if ((stall_o != 4'b0000) && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
            if (flush_o && (flush_cnt != '1))               flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

    assign perf_stall_cnt_o = stall_cnt;
    assign perf_flush_cnt_o = flush_cnt;
    assign mp_done_o        = (mp_state == MP_DONE);

endmodule
